seq_detect_param: RTL and testbench

- Parametrised Mealy sequence detector. It generalises the fixed 4-bit 0101 detector to a LEN-bit pattern.
- The pattern is runtime-loadable, overlap or non-overlap is selectable at runtime, and an input-enable qualifies each bit.
- A saturating match counter with synchronous clear is included.
- Sits in the serial-input path; out feeds downstream control logic combinationally (Mealy), match_cnt feeds status readback.

---
 rtl/seq_detect_param.sv | 83 ++++++++
 tb/tb_seq_detect_param.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/seq_detect_param.sv
// Mealy detector for a runtime-loadable LEN-bit pattern, with overlap select,
// a per-bit enable and a saturating match counter with synchronous clear.
module seq_detect_param #(
  parameter int unsigned    LEN     = 4,
  parameter logic [LEN-1:0] PATTERN = 4'b0101,
  parameter int unsigned    CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             x,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [LEN-1:0]   pat_in,
  input  logic             clr_cnt,
  output logic             out,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int unsigned          FILL_W   = $clog2(LEN);
  localparam logic [FILL_W-1:0]    FILL_MAX = FILL_W'(LEN - 1);
  localparam logic [CNT_W-1:0]     CNT_MAX  = {CNT_W{1'b1}};

  logic [LEN-1:0]    pat_q, pat_d;
  logic [LEN-2:0]    hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LEN-1:0]    window;
  logic              accept;
  logic              match;

  // fill gates the compare, so stale or reset-zero history can never match
  always_comb begin
    accept = en & ~pat_load;
    window = {hist_q, x};
    match  = accept && (fill_q == FILL_MAX) && (window == pat_q);
  end

  always_comb begin
    pat_d  = pat_q;
    hist_d = hist_q;
    fill_d = fill_q;
    if (pat_load) begin
      pat_d  = pat_in;
      hist_d = '0;
      fill_d = '0;
    end else if (en) begin
      hist_d = window[LEN-2:0];
      if (match && !overlap) begin
        fill_d = '0;
      end else if (fill_q != FILL_MAX) begin
        fill_d = fill_q + FILL_W'(1);
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (match && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_q  <= PATTERN;
      hist_q <= '0;
      fill_q <= '0;
      cnt_q  <= '0;
    end else begin
      pat_q  <= pat_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out       = match;
  assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Randomised and directed bench for seq_detect_param: a behavioural model
// queues the expected out/match_cnt per cycle and a monitor checks them.
module tb_seq_detect_param;

  localparam int LEN   = 4;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en = 1'b0, x = 1'b0, overlap = 1'b0, pat_load = 1'b0, clr_cnt = 1'b0;
  logic [LEN-1:0]   pat_in = '0;
  logic             out;
  logic [CNT_W-1:0] match_cnt;

  seq_detect_param #(.LEN(LEN), .PATTERN(4'b0101), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .x(x), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in), .clr_cnt(clr_cnt),
    .out(out), .match_cnt(match_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit exp_out;
    int exp_cnt;
  } exp_t;

  exp_t     sb[$];
  int       vectors = 0;
  int       miscompares = 0;

  // reference model: accepted-bit history plus count of bits in current segment
  logic [LEN-1:0] mpat;
  bit             mbits[$];
  int             seg;
  int             mcnt;

  task automatic model_reset();
    mpat = 4'b0101;
    mbits.delete();
    seg  = 0;
    mcnt = 0;
  endtask

  function automatic bit model_match(bit e, bit ld, bit xv);
    logic [LEN-1:0] w;
    if (!e || ld) return 1'b0;
    if (seg < LEN - 1) return 1'b0;
    w[0] = xv;
    for (int i = 0; i < LEN - 1; i++) w[i+1] = mbits[mbits.size() - 1 - i];
    return w == mpat;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      vectors++;
      if (out !== e.exp_out) begin
        miscompares++;
        $display("FAIL out: got %b expected %b at %0t", out, e.exp_out, $time);
      end
      vectors++;
      if (match_cnt !== CNT_W'(e.exp_cnt)) begin
        miscompares++;
        $display("FAIL match_cnt: got %0d expected %0d at %0t", match_cnt, e.exp_cnt, $time);
      end
    end
  end

  task automatic step(bit e, bit xv, bit ov, bit ld, logic [LEN-1:0] pi, bit cl, bit rv);
    exp_t ex;
    bit   m;
    @(posedge clk);
    #1;
    rst = rv; en = e; x = xv; overlap = ov; pat_load = ld; pat_in = pi; clr_cnt = cl;
    if (!rv) begin
      model_reset();
      ex.exp_out = 1'b0;
      ex.exp_cnt = 0;
      sb.push_back(ex);
    end else begin
      m = model_match(e, ld, xv);
      ex.exp_out = m;
      ex.exp_cnt = mcnt;
      sb.push_back(ex);
      if (ld) begin
        mpat = pi;
        mbits.delete();
        seg = 0;
      end else if (e) begin
        mbits.push_back(xv);
        if (mbits.size() > 8) void'(mbits.pop_front());
        if (m && !ov) seg = 0;
        else seg++;
      end
      if (cl) mcnt = 0;
      else if (m && mcnt < CMAX) mcnt++;
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic feed(logic [15:0] s, int n, bit ov);
    for (int i = n - 1; i >= 0; i--) step(1'b1, s[i], ov, 1'b0, '0, 1'b0, 1'b1);
  endtask

  // direct readback of the counter during an idle cycle against a hand value
  task automatic check_cnt(string name, int exp_v);
    vectors++;
    if (match_cnt !== CNT_W'(exp_v)) begin
      miscompares++;
      $display("FAIL %s: match_cnt got %0d expected %0d", name, match_cnt, exp_v);
    end
  endtask

  initial begin
    model_reset();
    do_reset();

    feed(16'b0101_0101, 8, 1'b1); idle(); check_cnt("overlap_0101x2", 3);
    do_reset();
    feed(16'b0101_0101, 8, 1'b0); idle(); check_cnt("nonoverlap_0101x2", 2);
    do_reset();
    feed(16'b101, 3, 1'b1); idle(); check_cnt("short_prefix", 0);
    do_reset();
    feed(16'b0101, 4, 1'b1); idle(); check_cnt("first_full", 1);

    do_reset();
    step(1'b1, 1'b0, 1'b1, 1'b1, 4'b1101, 1'b0, 1'b1);
    feed(16'b110_1101, 7, 1'b1); idle(); check_cnt("load_1101", 2);
    feed(16'b110, 3, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 4'b1101, 1'b0, 1'b1);
    feed(16'b110, 3, 1'b1); idle(); check_cnt("load_midway_partial", 2);
    feed(16'b1, 1, 1'b1); idle(); check_cnt("load_midway_full", 3);

    do_reset();
    feed(16'b01, 2, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, i[0], 1'b1, 1'b0, '0, 1'b0, 1'b1);
    feed(16'b01, 2, 1'b1); idle(); check_cnt("en_gap", 1);

    do_reset();
    step(1'b1, 1'b0, 1'b1, 1'b1, 4'b1111, 1'b0, 1'b1);
    for (int i = 0; i < 300; i++) step(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b1);
    idle(); check_cnt("saturate", CMAX);
    step(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b1);
    idle(); check_cnt("clr_beats_inc", 0);

    do_reset();
    feed(16'b010, 3, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    feed(16'b1, 1, 1'b1);
    feed(16'b0101, 4, 1'b1); idle(); check_cnt("after_midstream_reset", 1);

    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
           $urandom_range(0, 39) == 0, 4'($urandom), $urandom_range(0, 39) == 0,
           $urandom_range(0, 99) != 0);
    end
    idle();

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected entries left unchecked, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
